// File: rtl/store_fence_ctrl_pkg.sv
// Shared types for the store issue / fence controller: core configuration,
// write-through dcache handshake bundle and the fence FSM state encoding.
package store_fence_ctrl_pkg;

    // Subset of the core configuration consumed by the store path.
    typedef struct packed {
        logic [31:0] MaxOutstandingStores;
        logic        DcacheFlushOnFence;
    } cva6_cfg_t;

    // Default configuration: cv32a60x store credits, no flush on fence.
    localparam cva6_cfg_t cva6_cfg_empty = '{
        MaxOutstandingStores: 32'd7,
        DcacheFlushOnFence:   1'b0
    };

    // Write-through dcache store handshake.
    typedef struct packed {
        logic req;
        logic gnt;
        logic ack;
    } dcache_wt_hs_t;

    // Fence sequencing states.
    typedef enum logic [1:0] {
        FENCE_IDLE  = 2'd0,
        FENCE_DRAIN = 2'd1,
        FENCE_FLUSH = 2'd2,
        FENCE_DONE  = 2'd3
    } fence_state_e;

    // Width needed to hold a credit count in 0..max_out.
    function automatic int unsigned cnt_width(input int unsigned max_out);
        return $clog2(max_out + 32'd1);
    endfunction

endpackage

// File: rtl/store_fence_ctrl_credit_cnt.sv
// Outstanding-store credit counter: +1 per issued store, -1 per write-through
// ack, hold when both happen together. Decrement at zero is dropped and
// reported so the controller can flag the protocol error.
module store_credit_cnt
    import store_fence_ctrl_pkg::*;
#(
    parameter int unsigned MaxCount = 32'd7,
    parameter int unsigned CntW     = 32'd3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] count_o,
    output logic            at_max_o,
    output logic            at_zero_o,
    output logic            underflow_o
);

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    assign at_max_o    = (count_q == CntW'(MaxCount));
    assign at_zero_o   = (count_q == '0);
    assign underflow_o = dec_i & ~inc_i & at_zero_o;
    assign count_o     = count_q;

    // Next credit count: increment only, decrement only, or hold.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && !at_max_o) begin
            count_d = count_q + CntW'(1);
        end else if (dec_i && !inc_i && !at_zero_o) begin
            count_d = count_q - CntW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Credit count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/store_fence_ctrl.sv
// Store issue and fence controller in front of a write-through dcache.
// Stores are issued while credits remain; a fence blocks issue, waits for all
// outstanding stores to be acknowledged, optionally flushes the dcache and
// then signals completion for one cycle.
module store_fence_ctrl
    import store_fence_ctrl_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg        = cva6_cfg_empty,
    parameter int unsigned MaxOutstanding = CVA6Cfg.MaxOutstandingStores,
    parameter bit          FlushOnFence   = CVA6Cfg.DcacheFlushOnFence
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                st_valid_i,
    output logic                                st_ready_o,
    output logic                                cache_req_o,
    input  logic                                cache_gnt_i,
    input  logic                                cache_ack_i,
    input  logic                                fence_req_i,
    output logic                                fence_done_o,
    output logic                                flush_req_o,
    input  logic                                flush_ack_i,
    output logic [cnt_width(MaxOutstanding)-1:0] outstanding_o,
    output logic                                busy_o,
    output logic                                err_o
);

    localparam int unsigned CntW = cnt_width(MaxOutstanding);

    fence_state_e    state_q;
    fence_state_e    state_d;
    logic            err_q;
    logic            err_d;
    logic            issue_s;
    logic            at_max_s;
    logic            at_zero_s;
    logic            underflow_s;
    logic [CntW-1:0] count_s;

    store_credit_cnt #(
        .MaxCount (MaxOutstanding),
        .CntW     (CntW)
    ) u_credit_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_i       (issue_s),
        .dec_i       (cache_ack_i),
        .count_o     (count_s),
        .at_max_o    (at_max_s),
        .at_zero_o   (at_zero_s),
        .underflow_o (underflow_s)
    );

    // Store issue gating: only in IDLE, never in the cycle a fence arrives,
    // and only while credits remain.
    always_comb begin
        cache_req_o = st_valid_i & (state_q == FENCE_IDLE) & ~fence_req_i & ~at_max_s;
        st_ready_o  = cache_req_o & cache_gnt_i;
        issue_s     = st_ready_o;
    end

    // Fence sequencing, sticky error capture and state-decoded outputs.
    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        fence_done_o = 1'b0;
        flush_req_o  = 1'b0;

        case (state_q)
            FENCE_IDLE: begin
                if (fence_req_i) begin
                    state_d = FENCE_DRAIN;
                end else begin
                    state_d = FENCE_IDLE;
                end
            end
            FENCE_DRAIN: begin
                if (at_zero_s) begin
                    state_d = FlushOnFence ? FENCE_FLUSH : FENCE_DONE;
                end else begin
                    state_d = FENCE_DRAIN;
                end
            end
            FENCE_FLUSH: begin
                flush_req_o = 1'b1;
                if (flush_ack_i) begin
                    state_d = FENCE_DONE;
                end else begin
                    state_d = FENCE_FLUSH;
                end
            end
            FENCE_DONE: begin
                fence_done_o = 1'b1;
                state_d      = FENCE_IDLE;
            end
            default: begin
                state_d = FENCE_IDLE;
            end
        endcase

        // A fence outside IDLE is dropped, an ack with nothing outstanding
        // is dropped; both are remembered until reset.
        if ((fence_req_i && (state_q != FENCE_IDLE)) || underflow_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // FSM state and error flag registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FENCE_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign outstanding_o = count_s;
    assign busy_o        = (state_q != FENCE_IDLE) | ~at_zero_s;
    assign err_o         = err_q;

endmodule

// File: tb/tb_store_fence_ctrl.sv
// Scoreboard bench for store_fence_ctrl: two instances (without and with
// dcache flush on fence) share all inputs. Stimulus pushes expected output
// values tagged with a cycle number; a negedge monitor pops and compares.
module tb_store_fence_ctrl;
    import store_fence_ctrl_pkg::*;

    localparam int S_OUT  = 0;
    localparam int S_ERR  = 1;
    localparam int S_FD   = 2;
    localparam int S_FR   = 3;
    localparam int S_BUSY = 4;
    localparam int S_CREQ = 5;
    localparam int S_RDY  = 6;

    typedef struct {
        int cyc;
        int d;
        int s;
        int v;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, st_valid, cache_gnt, cache_ack, fence_req, flush_ack;
    logic st_ready0, cache_req0, fence_done0, flush_req0, busy0, err0;
    logic st_ready1, cache_req1, fence_done1, flush_req1, busy1, err1;
    logic [2:0] outst0, outst1;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    store_fence_ctrl #(.FlushOnFence(1'b0)) d0 (
        .clk_i(clk), .rst_i(rst), .st_valid_i(st_valid), .st_ready_o(st_ready0),
        .cache_req_o(cache_req0), .cache_gnt_i(cache_gnt), .cache_ack_i(cache_ack),
        .fence_req_i(fence_req), .fence_done_o(fence_done0), .flush_req_o(flush_req0),
        .flush_ack_i(flush_ack), .outstanding_o(outst0), .busy_o(busy0), .err_o(err0)
    );

    store_fence_ctrl #(.FlushOnFence(1'b1)) d1 (
        .clk_i(clk), .rst_i(rst), .st_valid_i(st_valid), .st_ready_o(st_ready1),
        .cache_req_o(cache_req1), .cache_gnt_i(cache_gnt), .cache_ack_i(cache_ack),
        .fence_req_i(fence_req), .fence_done_o(fence_done1), .flush_req_o(flush_req1),
        .flush_ack_i(flush_ack), .outstanding_o(outst1), .busy_o(busy1), .err_o(err1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sample(input int d, input int s);
        logic [2:0] o;
        logic e, fd, fr, b, cr, r;
        if (d == 0) begin
            o = outst0; e = err0; fd = fence_done0; fr = flush_req0;
            b = busy0; cr = cache_req0; r = st_ready0;
        end else begin
            o = outst1; e = err1; fd = fence_done1; fr = flush_req1;
            b = busy1; cr = cache_req1; r = st_ready1;
        end
        case (s)
            S_OUT:   return int'(o);
            S_ERR:   return int'(e);
            S_FD:    return int'(fd);
            S_FR:    return int'(fr);
            S_BUSY:  return int'(b);
            S_CREQ:  return int'(cr);
            S_RDY:   return int'(r);
            default: return -1;
        endcase
    endfunction

    function automatic string sname(input int s);
        case (s)
            S_OUT:   return "outstanding";
            S_ERR:   return "err";
            S_FD:    return "fence_done";
            S_FR:    return "flush_req";
            S_BUSY:  return "busy";
            S_CREQ:  return "cache_req";
            S_RDY:   return "st_ready";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        exp_t e;
        int   act;
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            e   = q.pop_front();
            act = sample(e.d, e.s);
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL stale_%s dut%0d: due cycle %0d, seen at cycle %0d",
                         sname(e.s), e.d, e.cyc, cyc);
            end else if (act != e.v) begin
                errors++;
                $display("FAIL %s dut%0d cycle %0d: actual %0d required %0d",
                         sname(e.s), e.d, cyc, act, e.v);
            end
        end
    end

    task automatic push(input int d, input int s, input int v);
        exp_t e;
        e.cyc = cyc; e.d = d; e.s = s; e.v = v;
        q.push_back(e);
    endtask

    task automatic exp_both(input int s, input int v);
        push(0, s, v);
        push(1, s, v);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; st_valid = 1'b0; cache_gnt = 1'b0; cache_ack = 1'b0;
        fence_req = 1'b0; flush_ack = 1'b0;
        step;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            push(d, S_OUT, 0); push(d, S_ERR, 0); push(d, S_FD, 0);
            push(d, S_FR, 0); push(d, S_BUSY, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Credit limit: 7 issues, then blocked until an ack returns a credit.
        do_reset;
        st_valid = 1'b1; cache_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_both(S_OUT, (i < 7) ? i : 7);
            exp_both(S_CREQ, (i < 7) ? 1 : 0);
            exp_both(S_RDY, (i < 7) ? 1 : 0);
            step;
        end
        cache_ack = 1'b1;
        exp_both(S_OUT, 7); exp_both(S_CREQ, 0);
        step;
        cache_ack = 1'b0;
        exp_both(S_OUT, 6); exp_both(S_CREQ, 1); exp_both(S_RDY, 1);
        step;
        st_valid = 1'b0;
        exp_both(S_OUT, 7); exp_both(S_CREQ, 0); exp_both(S_ERR, 0);
        step;

        // Issue and ack together at count 3: count holds, no error.
        do_reset;
        st_valid = 1'b1; cache_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_both(S_OUT, i);
            step;
        end
        cache_ack = 1'b1;
        exp_both(S_OUT, 3); exp_both(S_RDY, 1);
        step;
        cache_ack = 1'b0; st_valid = 1'b0;
        exp_both(S_OUT, 3); exp_both(S_ERR, 0);
        step;

        // Fence with 2 outstanding, acks at +3 and +5, issue blocked throughout.
        do_reset;
        st_valid = 1'b1; cache_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_both(S_OUT, i);
            step;
        end
        for (int k = 0; k <= 10; k++) begin
            fence_req = (k == 0);
            st_valid  = (k <= 7);
            cache_ack = (k == 3 || k == 5);
            flush_ack = (k == 8);
            exp_both(S_OUT, (k <= 3) ? 2 : ((k <= 5) ? 1 : 0));
            exp_both(S_ERR, 0);
            if (k <= 7) exp_both(S_CREQ, 0);
            push(0, S_FD, int'(k == 7));
            push(1, S_FD, int'(k == 9));
            push(0, S_FR, 0);
            push(1, S_FR, int'(k == 7 || k == 8));
            push(0, S_BUSY, int'(k <= 7));
            push(1, S_BUSY, int'(k <= 9));
            step;
        end

        // Fence at count 0: no-flush completes at +2; flush ack 4 cycles after rise.
        do_reset;
        for (int k = 0; k <= 8; k++) begin
            fence_req = (k == 0);
            flush_ack = (k == 6);
            push(0, S_FD, int'(k == 2));
            push(0, S_FR, 0);
            push(1, S_FR, int'(k >= 2 && k <= 6));
            push(1, S_FD, int'(k == 7));
            exp_both(S_OUT, 0);
            step;
        end

        // Ack with nothing outstanding: sticky error, count stays 0.
        do_reset;
        cache_ack = 1'b1;
        exp_both(S_ERR, 0);
        step;
        cache_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_both(S_ERR, 1); exp_both(S_OUT, 0);
            step;
        end

        // Second fence while draining: error, not queued, single completion.
        do_reset;
        for (int k = 0; k <= 6; k++) begin
            fence_req = (k == 0 || k == 1);
            flush_ack = (k == 3);
            exp_both(S_ERR, int'(k >= 2));
            push(0, S_FD, int'(k == 2));
            push(1, S_FR, int'(k == 2 || k == 3));
            push(1, S_FD, int'(k == 4));
            exp_both(S_OUT, 0);
            step;
        end

        // Reset while draining 4 stores: everything clears, no completion.
        do_reset;
        st_valid = 1'b1; cache_gnt = 1'b1;
        for (int i = 0; i < 4; i++) step;
        st_valid = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            fence_req = (k == 0);
            flush_ack = (k == 1);
            rst       = (k == 2);
            if (k <= 2) begin
                exp_both(S_OUT, 4); exp_both(S_BUSY, 1);
            end else begin
                exp_both(S_OUT, 0); exp_both(S_BUSY, 0); exp_both(S_FR, 0);
            end
            exp_both(S_FD, 0);
            step;
        end

        // Reset while flushing: flush request drops, no completion follows.
        do_reset;
        for (int k = 0; k <= 6; k++) begin
            fence_req = (k == 0);
            rst       = (k == 2);
            push(1, S_FR, int'(k == 2));
            push(0, S_FD, int'(k == 2));
            push(1, S_FD, 0);
            if (k >= 3) begin
                exp_both(S_BUSY, 0); exp_both(S_OUT, 0);
            end
            step;
        end
        rst = 1'b0; fence_req = 1'b0;
        step;
        step;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
